// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared codes, FSM states and size helper for the data-memory responder
package dmem_pkg;

  localparam logic [2:0] MEM_NONE = 3'd0;
  localparam logic [2:0] MEM_B    = 3'd1;
  localparam logic [2:0] MEM_H    = 3'd2;
  localparam logic [2:0] MEM_W    = 3'd3;
  localparam logic [2:0] MEM_D    = 3'd4;
  localparam logic [2:0] MEM_BU   = 3'd5;
  localparam logic [2:0] MEM_HU   = 3'd6;
  localparam logic [2:0] MEM_WU   = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Store codes share the load numbering for sizes 1-4, so one table serves both.
  function automatic logic [3:0] size_bytes(input logic [2:0] code);
    case (code)
      MEM_B, MEM_BU: size_bytes = 4'd1;
      MEM_H, MEM_HU: size_bytes = 4'd2;
      MEM_W, MEM_WU: size_bytes = 4'd4;
      MEM_D:         size_bytes = 4'd8;
      default:       size_bytes = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - load/store request and response bundle between core and responder
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  mem_read;
  logic [2:0]  mem_write;
  logic [63:0] addr;
  logic [63:0] write_data;
  logic        resp_valid;
  logic [63:0] read_data;
  logic        resp_err;

  modport master (
    output req_valid, mem_read, mem_write, addr, write_data,
    input  req_ready, resp_valid, read_data, resp_err
  );

  modport slave (
    input  req_valid, mem_read, mem_write, addr, write_data,
    output req_ready, resp_valid, read_data, resp_err
  );
endinterface

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - byte-lane steering for stores, extract/extend for loads, alignment check
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  ld_code_i,
  input  logic [2:0]  st_code_i,
  input  logic [2:0]  byte_off_i,
  input  logic [63:0] wdata_i,
  input  logic [63:0] rword_i,
  output logic [7:0]  be_o,
  output logic [63:0] wword_o,
  output logic [63:0] rdata_o,
  output logic        misalign_o
);

  logic [3:0]  st_bytes;
  logic [3:0]  acc_bytes;
  logic [7:0]  be_base;
  logic [63:0] shifted;

  always_comb begin
    st_bytes  = size_bytes(st_code_i);
    acc_bytes = (st_code_i != MEM_NONE) ? st_bytes : size_bytes(ld_code_i);

    case (st_bytes)
      4'd1:    be_base = 8'h01;
      4'd2:    be_base = 8'h03;
      4'd4:    be_base = 8'h0F;
      4'd8:    be_base = 8'hFF;
      default: be_base = 8'h00;
    endcase
    be_o    = be_base << byte_off_i;
    wword_o = wdata_i << {byte_off_i, 3'b000};

    shifted = rword_i >> {byte_off_i, 3'b000};
    case (ld_code_i)
      MEM_B:   rdata_o = {{56{shifted[7]}},  shifted[7:0]};
      MEM_H:   rdata_o = {{48{shifted[15]}}, shifted[15:0]};
      MEM_W:   rdata_o = {{32{shifted[31]}}, shifted[31:0]};
      MEM_D:   rdata_o = shifted;
      MEM_BU:  rdata_o = {56'd0, shifted[7:0]};
      MEM_HU:  rdata_o = {48'd0, shifted[15:0]};
      MEM_WU:  rdata_o = {32'd0, shifted[31:0]};
      default: rdata_o = 64'd0;
    endcase

    case (acc_bytes)
      4'd2:    misalign_o = byte_off_i[0];
      4'd4:    misalign_o = |byte_off_i[1:0];
      4'd8:    misalign_o = |byte_off_i;
      default: misalign_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - fixed-latency data-memory responder with 64-bit little-endian storage
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 512,
  parameter int LATENCY     = 2
) (
  input logic             clk,
  input logic             reset,
  dmem_responder_if.slave bus
);

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam bit DIRECT = (LATENCY == 1);

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      rd_q;
  logic [2:0]      wr_q;
  logic [63:0]     addr_q;
  logic [63:0]     wdata_q;
  logic [63:0]     rdata_q;
  logic            err_q;
  logic [63:0]     mem_q [0:DEPTH_WORDS-1];

  logic            accept;
  logic            enter_resp;
  logic            req_err;
  logic [2:0]      cur_rd;
  logic [2:0]      cur_wr;
  logic [63:0]     cur_addr;
  logic [63:0]     cur_wdata;
  logic [AW-1:0]   idx;
  logic [7:0]      be;
  logic [63:0]     wword;
  logic [63:0]     ld_data;
  logic            misalign;

  assign bus.req_ready  = (state_q == IDLE) && !reset;
  assign bus.resp_valid = (state_q == RESP);
  assign bus.read_data  = rdata_q;
  assign bus.resp_err   = err_q;
  assign accept         = bus.req_valid && bus.req_ready;

  // In IDLE the live bus fields are used so a single-cycle latency can respond on the accept edge.
  assign cur_rd    = (state_q == IDLE) ? bus.mem_read   : rd_q;
  assign cur_wr    = (state_q == IDLE) ? bus.mem_write  : wr_q;
  assign cur_addr  = (state_q == IDLE) ? bus.addr       : addr_q;
  assign cur_wdata = (state_q == IDLE) ? bus.write_data : wdata_q;
  assign idx       = cur_addr[AW+2:3];

  dmem_lane_align u_align (
    .ld_code_i  (cur_rd),
    .st_code_i  (cur_wr),
    .byte_off_i (cur_addr[2:0]),
    .wdata_i    (cur_wdata),
    .rword_i    (mem_q[idx]),
    .be_o       (be),
    .wword_o    (wword),
    .rdata_o    (ld_data),
    .misalign_o (misalign)
  );

  assign req_err = ((cur_rd != MEM_NONE) && (cur_wr != MEM_NONE))
                 || (cur_wr > MEM_D)
                 || misalign
                 || (cur_addr[63:3] >= 61'(DEPTH_WORDS));

  assign enter_resp = ((state_q == WAIT) && (cnt_q == '0))
                    || (DIRECT && (state_q == IDLE) && accept);

  // Storage has no reset so the array survives a reset pulse.
  always_ff @(posedge clk) begin
    if (!reset && enter_resp && (cur_wr != MEM_NONE) && !req_err) begin
      for (int i = 0; i < 8; i++) begin
        if (be[i]) mem_q[idx][i*8 +: 8] <= wword[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rd_q    <= MEM_NONE;
      wr_q    <= MEM_NONE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            rd_q    <= bus.mem_read;
            wr_q    <= bus.mem_write;
            addr_q  <= bus.addr;
            wdata_q <= bus.write_data;
            cnt_q   <= CW'(LATENCY - 1);
            state_q <= DIRECT ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == '0) state_q <= RESP;
          else             cnt_q   <= cnt_q - CW'(1);
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase

      if (enter_resp) begin
        err_q   <= req_err;
        rdata_q <= (req_err || (cur_rd == MEM_NONE)) ? 64'd0 : ld_data;
      end else if (state_q == RESP) begin
        err_q   <= 1'b0;
        rdata_q <= 64'd0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int LAT = 2;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  dmem_responder_if bus ();

  dmem_responder #(.DEPTH_WORDS(512), .LATENCY(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic issue(input logic [2:0] rd, input logic [2:0] wr, input logic [63:0] a,
                       input logic [63:0] wd, output logic [63:0] data, output logic err,
                       output int lat, output logic [63:0] after);
    int waited = 0;
    data = '0; err = 1'b0; lat = -1; after = '0;
    bus.req_valid = 1'b1; bus.mem_read = rd; bus.mem_write = wr;
    bus.addr = a; bus.write_data = wd;
    while (!bus.req_ready && waited < 20) begin
      @(posedge clk); #1; waited++;
    end
    if (!bus.req_ready) begin
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.mem_read = MEM_NONE; bus.mem_write = MEM_NONE;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (bus.resp_valid) begin
        lat = k; data = bus.read_data; err = bus.resp_err;
        break;
      end
    end
    @(posedge clk); #1;
    after = bus.read_data;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b exp=0", bus.req_ready); end
    total++; if (bus.resp_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", bus.resp_valid); end
    total++; if (bus.read_data !== 64'd0) begin bad++; $display("FAIL rst_data got=%h exp=0", bus.read_data); end
    total++; if (bus.resp_err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", bus.resp_err); end
    reset = 1'b0;
    #1;
    total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL idle_ready got=%b exp=1", bus.req_ready); end
  endtask

  task automatic test_store_load();
    logic [63:0] d, af; logic e; int l;
    issue(MEM_NONE, MEM_D, 64'h10, 64'h1122334455667788, d, e, l, af);
    total++; if (l !== LAT) begin bad++; $display("FAIL sd_lat got=%0d exp=%0d", l, LAT); end
    total++; if (e !== 1'b0 || d !== 64'd0) begin bad++; $display("FAIL sd_resp got=%b/%h exp=0/0", e, d); end
    issue(MEM_D, MEM_NONE, 64'h10, 64'h0, d, e, l, af);
    total++; if (l !== LAT) begin bad++; $display("FAIL ld_lat got=%0d exp=%0d", l, LAT); end
    total++; if (d !== 64'h1122334455667788 || e !== 1'b0) begin bad++; $display("FAIL ld_data got=%h/%b exp=1122334455667788/0", d, e); end
    total++; if (af !== 64'd0) begin bad++; $display("FAIL ld_clear got=%h exp=0", af); end
  endtask

  task automatic test_sub_word();
    logic [63:0] d, af; logic e; int l;
    issue(MEM_NONE, MEM_B, 64'h13, 64'hF0, d, e, l, af);
    total++; if (e !== 1'b0) begin bad++; $display("FAIL sb_err got=%b exp=0", e); end
    issue(MEM_B, MEM_NONE, 64'h13, 64'h0, d, e, l, af);
    total++; if (d !== 64'hFFFFFFFFFFFFFFF0) begin bad++; $display("FAIL lb got=%h exp=fffffffffffffff0", d); end
    issue(MEM_BU, MEM_NONE, 64'h13, 64'h0, d, e, l, af);
    total++; if (d !== 64'h00000000000000F0) begin bad++; $display("FAIL lbu got=%h exp=f0", d); end
    issue(MEM_D, MEM_NONE, 64'h10, 64'h0, d, e, l, af);
    total++; if (d !== 64'h11223344F0667788) begin bad++; $display("FAIL ld_merge got=%h exp=11223344f0667788", d); end
    issue(MEM_H, MEM_NONE, 64'h14, 64'h0, d, e, l, af);
    total++; if (d !== 64'h0000000000003344) begin bad++; $display("FAIL lh got=%h exp=3344", d); end
    issue(MEM_W, MEM_NONE, 64'h10, 64'h0, d, e, l, af);
    total++; if (d !== 64'hFFFFFFFFF0667788) begin bad++; $display("FAIL lw got=%h exp=fffffffff0667788", d); end
    issue(MEM_WU, MEM_NONE, 64'h10, 64'h0, d, e, l, af);
    total++; if (d !== 64'h00000000F0667788) begin bad++; $display("FAIL lwu got=%h exp=f0667788", d); end
    issue(MEM_NONE, MEM_NONE, 64'h10, 64'h0, d, e, l, af);
    total++; if (d !== 64'd0 || e !== 1'b0 || l !== LAT) begin bad++; $display("FAIL noop got=%h/%b/%0d exp=0/0/%0d", d, e, l, LAT); end
  endtask

  task automatic test_errors();
    logic [63:0] d, af; logic e; int l;
    issue(MEM_W, MEM_NONE, 64'h12, 64'h0, d, e, l, af);
    total++; if (e !== 1'b1 || d !== 64'd0) begin bad++; $display("FAIL lw_misalign got=%b/%h exp=1/0", e, d); end
    issue(MEM_NONE, MEM_W, 64'h16, 64'hDEADBEEF, d, e, l, af);
    total++; if (e !== 1'b1) begin bad++; $display("FAIL sw_misalign got=%b exp=1", e); end
    issue(MEM_D, MEM_NONE, 64'h10, 64'h0, d, e, l, af);
    total++; if (d !== 64'h11223344F0667788 || e !== 1'b0) begin bad++; $display("FAIL ld_untouched got=%h/%b exp=11223344f0667788/0", d, e); end
    issue(MEM_D, MEM_NONE, 64'h1000, 64'h0, d, e, l, af);
    total++; if (e !== 1'b1 || d !== 64'd0) begin bad++; $display("FAIL ld_range got=%b/%h exp=1/0", e, d); end
    issue(MEM_D, MEM_NONE, 64'hFF8, 64'h0, d, e, l, af);
    total++; if (e !== 1'b0 || d !== 64'd0) begin bad++; $display("FAIL ld_last got=%b/%h exp=0/0", e, d); end
    issue(MEM_B, MEM_B, 64'h10, 64'h0, d, e, l, af);
    total++; if (e !== 1'b1 || d !== 64'd0) begin bad++; $display("FAIL both_codes got=%b/%h exp=1/0", e, d); end
    issue(MEM_NONE, 3'd5, 64'h10, 64'h0, d, e, l, af);
    total++; if (e !== 1'b1 || af !== 64'd0) begin bad++; $display("FAIL wr_illegal got=%b/%h exp=1/0", e, af); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_rdy = 8'b0001_0001;
    logic [7:0] exp_rv  = 8'b1000_1000;
    bus.req_valid = 1'b1; bus.mem_read = MEM_D; bus.mem_write = MEM_NONE; bus.addr = 64'h10;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      total++; if (bus.req_ready !== exp_rdy[i]) begin bad++; $display("FAIL b2b_ready[%0d] got=%b exp=%b", i, bus.req_ready, exp_rdy[i]); end
      total++; if (bus.resp_valid !== exp_rv[i]) begin bad++; $display("FAIL b2b_valid[%0d] got=%b exp=%b", i, bus.resp_valid, exp_rv[i]); end
      if (exp_rv[i]) begin
        total++; if (bus.read_data !== 64'h11223344F0667788) begin bad++; $display("FAIL b2b_data[%0d] got=%h exp=11223344f0667788", i, bus.read_data); end
      end
    end
    bus.req_valid = 1'b0; bus.mem_read = MEM_NONE;
    repeat (2) @(posedge clk);
    #1;
    total++; if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin bad++; $display("FAIL b2b_idle got=%b/%b exp=0/1", bus.resp_valid, bus.req_ready); end
  endtask

  task automatic test_reset_mid();
    logic [63:0] d, af; logic e; int l;
    bus.req_valid = 1'b1; bus.mem_read = MEM_NONE; bus.mem_write = MEM_D;
    bus.addr = 64'h20; bus.write_data = 64'hAB;
    total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL mid_ready got=%b exp=1", bus.req_ready); end
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.mem_write = MEM_NONE;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      total++; if (bus.resp_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid[%0d] got=%b exp=0", i, bus.resp_valid); end
    end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      total++; if (bus.resp_valid !== 1'b0) begin bad++; $display("FAIL mid_post_valid[%0d] got=%b exp=0", i, bus.resp_valid); end
    end
    issue(MEM_D, MEM_NONE, 64'h20, 64'h0, d, e, l, af);
    total++; if (d !== 64'd0 || e !== 1'b0 || l !== LAT) begin bad++; $display("FAIL mid_dropped got=%h/%b/%0d exp=0/0/%0d", d, e, l, LAT); end
  endtask

  initial begin
    reset = 1'b1;
    bus.req_valid = 1'b0; bus.mem_read = MEM_NONE; bus.mem_write = MEM_NONE;
    bus.addr = '0; bus.write_data = '0;
    test_reset();
    test_store_load();
    test_sub_word();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
